// File: rtl/load_align_unit.sv
// Memory-stage load unit: fetches one or two aligned words per load request and returns
// the byte-extracted, sign/zero-extended result, flagging illegal or misaligned loads.
module load_align_unit #(
    parameter int DATA_WIDTH  = 64,
    parameter int ADDR_WIDTH  = 64,
    parameter int MISALIGN_EN = 1
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [2:0]            i_func_3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  o_mem_req,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    input  logic                  i_mem_valid,
    input  logic [DATA_WIDTH-1:0] i_mem_data,
    output logic                  o_resp_valid,
    input  logic                  i_resp_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_load_addr_ma,
    output logic                  o_illegal_instr
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFFW  = $clog2(BYTES);

    typedef enum logic [1:0] {S_IDLE, S_ACC0, S_ACC1, S_RESP} state_t;

    // Handshakes: a transfer happens on a cycle where valid and ready are both high;
    // valid is held with its payload stable until that cycle.
    state_t                r_state;
    logic [2:0]            r_func_3;
    logic [OFFW-1:0]       r_off;
    logic                  r_cross;
    logic [DATA_WIDTH-1:0] r_lo;

    logic [OFFW-1:0]       w_off;
    logic [3:0]            w_size;
    logic [4:0]            w_end;
    logic                  w_illegal;
    logic                  w_misaligned;
    logic                  w_cross;

    always_comb begin
        w_off        = i_addr[OFFW-1:0];
        w_size       = 4'd1 << i_func_3[1:0];
        w_end        = {1'b0, 4'(w_off)} + {1'b0, w_size};
        w_misaligned = (4'(w_off) & (w_size - 4'd1)) != 4'd0;
        w_cross      = w_end > 5'(BYTES);
        w_illegal    = (i_func_3 == 3'b111) ||
                       ((DATA_WIDTH == 32) && ((i_func_3 == 3'b011) || (i_func_3 == 3'b110)));
    end

    logic [2*DATA_WIDTH-1:0] w_cat;
    logic [DATA_WIDTH-1:0]   w_low;
    logic [DATA_WIDTH-1:0]   w_ext;
    logic [6:0]              w_nbits;
    logic                    w_sign;

    // A non-crossing load sees a zero hi word; a crossing one merges the captured lo word.
    always_comb begin
        w_cat   = (r_state == S_ACC1) ? {i_mem_data, r_lo} : {{DATA_WIDTH{1'b0}}, i_mem_data};
        w_low   = DATA_WIDTH'(w_cat >> {r_off, 3'b000});
        w_nbits = 7'd8 << r_func_3[1:0];
        case (r_func_3[1:0])
            2'b00:   w_sign = w_low[7];
            2'b01:   w_sign = w_low[15];
            2'b10:   w_sign = w_low[31];
            default: w_sign = w_low[DATA_WIDTH-1];
        endcase
        w_sign = w_sign & ~r_func_3[2];
        w_ext  = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_ext[i] = (i < int'(w_nbits)) ? w_low[i] : w_sign;
        end
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            r_state         <= S_IDLE;
            r_func_3        <= '0;
            r_off           <= '0;
            r_cross         <= 1'b0;
            r_lo            <= '0;
            o_req_ready     <= 1'b1;
            o_mem_req       <= 1'b0;
            o_mem_addr      <= '0;
            o_resp_valid    <= 1'b0;
            o_data          <= '0;
            o_load_addr_ma  <= 1'b0;
            o_illegal_instr <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid && o_req_ready) begin
                        r_func_3    <= i_func_3;
                        r_off       <= w_off;
                        r_cross     <= w_cross;
                        o_req_ready <= 1'b0;
                        if (w_illegal) begin
                            r_state         <= S_RESP;
                            o_resp_valid    <= 1'b1;
                            o_illegal_instr <= 1'b1;
                            o_data          <= '0;
                        end else if (w_misaligned && (MISALIGN_EN == 0)) begin
                            r_state        <= S_RESP;
                            o_resp_valid   <= 1'b1;
                            o_load_addr_ma <= 1'b1;
                            o_data         <= '0;
                        end else begin
                            r_state    <= S_ACC0;
                            o_mem_req  <= 1'b1;
                            o_mem_addr <= i_addr & ~ADDR_WIDTH'(BYTES - 1);
                        end
                    end
                end
                S_ACC0: begin
                    if (i_mem_valid) begin
                        if (r_cross) begin
                            r_lo       <= i_mem_data;
                            o_mem_addr <= o_mem_addr + ADDR_WIDTH'(BYTES);
                            r_state    <= S_ACC1;
                        end else begin
                            o_mem_req    <= 1'b0;
                            o_data       <= w_ext;
                            o_resp_valid <= 1'b1;
                            r_state      <= S_RESP;
                        end
                    end
                end
                S_ACC1: begin
                    if (i_mem_valid) begin
                        o_mem_req    <= 1'b0;
                        o_data       <= w_ext;
                        o_resp_valid <= 1'b1;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (i_resp_ready) begin
                        o_resp_valid    <= 1'b0;
                        o_load_addr_ma  <= 1'b0;
                        o_illegal_instr <= 1'b0;
                        o_req_ready     <= 1'b1;
                        r_state         <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: a vector table on a MISALIGN_EN=1 instance plus
// hand sequences for stalls, reset abort, response hold and a MISALIGN_EN=0 instance.
module tb_load_align_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    // Instance with hardware misalignment handling.
    logic        i_req_valid = 1'b0, o_req_ready;
    logic [2:0]  i_func_3 = '0;
    logic [63:0] i_addr = '0;
    logic        o_mem_req, i_mem_valid;
    logic [63:0] o_mem_addr, i_mem_data;
    logic        o_resp_valid, i_resp_ready = 1'b0;
    logic [63:0] o_data;
    logic        o_load_addr_ma, o_illegal_instr;

    // Instance that only flags misaligned loads.
    logic        m_req_valid = 1'b0, m_req_ready;
    logic [2:0]  m_func_3 = '0;
    logic [63:0] m_addr = '0;
    logic        m_mem_req, m_mem_valid;
    logic [63:0] m_mem_addr, m_mem_data;
    logic        m_resp_valid, m_resp_ready = 1'b0;
    logic [63:0] m_data;
    logic        m_ma, m_ill;

    // Memory model: zero-wait unless mem_en is dropped; wrong addresses return a poison word.
    logic        mem_en = 1'b1;
    logic [63:0] mem_base = '0, mem_lo = '0, mem_hi = '0;
    int          acc_cnt = 0, m_acc_cnt = 0;
    assign i_mem_valid = o_mem_req & mem_en;
    assign i_mem_data  = (o_mem_addr == mem_base) ? mem_lo :
                         (o_mem_addr == mem_base + 64'd8) ? mem_hi : 64'hBAD0_BAD0_BAD0_BAD0;
    assign m_mem_valid = m_mem_req;
    assign m_mem_data  = 64'h8765_4321_0000_0000;

    always @(posedge clk) begin
        if (o_mem_req && i_mem_valid) acc_cnt <= acc_cnt + 1;
        if (m_mem_req && m_mem_valid) m_acc_cnt <= m_acc_cnt + 1;
    end

    load_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .MISALIGN_EN(1)) u_dut (
        .i_clk(clk), .i_arst(rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_func_3(i_func_3), .i_addr(i_addr),
        .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr),
        .i_mem_valid(i_mem_valid), .i_mem_data(i_mem_data),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_data(o_data), .o_load_addr_ma(o_load_addr_ma), .o_illegal_instr(o_illegal_instr)
    );

    load_align_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(64), .MISALIGN_EN(0)) u_dut_nm (
        .i_clk(clk), .i_arst(rst),
        .i_req_valid(m_req_valid), .o_req_ready(m_req_ready),
        .i_func_3(m_func_3), .i_addr(m_addr),
        .o_mem_req(m_mem_req), .o_mem_addr(m_mem_addr),
        .i_mem_valid(m_mem_valid), .i_mem_data(m_mem_data),
        .o_resp_valid(m_resp_valid), .i_resp_ready(m_resp_ready),
        .o_data(m_data), .o_load_addr_ma(m_ma), .o_illegal_instr(m_ill)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  func3;
        logic [63:0] addr;
        logic [63:0] lo;
        logic [63:0] hi;
        logic [63:0] data;
        logic        ma;
        logic        ill;
        int          lat;
        int          acc;
    } vec_t;

    vec_t vecs[14];

    // Starts at a negedge with the unit idle; ends at a negedge with the unit idle again.
    task automatic apply(input vec_t v, input string tag);
        int lat;
        int acc0;
        mem_base    = v.addr & ~64'h7;
        mem_lo      = v.lo;
        mem_hi      = v.hi;
        i_func_3    = v.func3;
        i_addr      = v.addr;
        i_req_valid = 1'b1;
        check({tag, ".req_ready"}, 64'(o_req_ready), 64'd1);
        acc0 = acc_cnt;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        i_func_3    = ~v.func3;
        i_addr      = ~v.addr;
        lat = 1;
        @(negedge clk);
        while (!o_resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(v.lat));
        check({tag, ".data"}, o_data, v.data);
        check({tag, ".ma"}, 64'(o_load_addr_ma), 64'(v.ma));
        check({tag, ".ill"}, 64'(o_illegal_instr), 64'(v.ill));
        check({tag, ".accesses"}, 64'(acc_cnt - acc0), 64'(v.acc));
        i_resp_ready = 1'b1;
        @(posedge clk); #1;
        i_resp_ready = 1'b0;
        @(negedge clk);
        check({tag, ".post_valid"}, 64'(o_resp_valid), 64'd0);
        check({tag, ".post_ready"}, 64'(o_req_ready), 64'd1);
    endtask

    initial begin
        //            func3   addr                    lo                      hi                      data                    ma    ill  lat acc
        vecs[0]  = '{3'b000, 64'h1003,              64'h0000_0000_8000_0000, 64'h0,                  64'hFFFF_FFFF_FFFF_FF80, 1'b0, 1'b0, 2, 1};
        vecs[1]  = '{3'b110, 64'h1004,              64'hDEAD_BEEF_0000_0000, 64'h0,                  64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0, 2, 1};
        vecs[2]  = '{3'b011, 64'h1006,              64'h2211_AAAA_BBBB_CCCC, 64'hFFEE_DDCC_6655_4433, 64'hDDCC_6655_4433_2211, 1'b0, 1'b0, 3, 2};
        vecs[3]  = '{3'b001, 64'h1000,              64'h0000_0000_0000_8001, 64'h0,                  64'hFFFF_FFFF_FFFF_8001, 1'b0, 1'b0, 2, 1};
        vecs[4]  = '{3'b101, 64'h1002,              64'h0000_0000_8001_0000, 64'h0,                  64'h0000_0000_0000_8001, 1'b0, 1'b0, 2, 1};
        vecs[5]  = '{3'b010, 64'h1004,              64'h8765_4321_0000_0000, 64'h0,                  64'hFFFF_FFFF_8765_4321, 1'b0, 1'b0, 2, 1};
        vecs[6]  = '{3'b001, 64'h1001,              64'h0000_0000_00AB_CD00, 64'h0,                  64'hFFFF_FFFF_FFFF_ABCD, 1'b0, 1'b0, 2, 1};
        vecs[7]  = '{3'b001, 64'h1007,              64'h7F11_1111_1111_1111, 64'h2222_2222_2222_2201, 64'h0000_0000_0000_017F, 1'b0, 1'b0, 3, 2};
        vecs[8]  = '{3'b010, 64'h1005,              64'hC3B2_A100_0000_0000, 64'h5555_5555_5555_55F4, 64'hFFFF_FFFF_F4C3_B2A1, 1'b0, 1'b0, 3, 2};
        vecs[9]  = '{3'b100, 64'h1007,              64'hFE00_0000_0000_0000, 64'h0,                  64'h0000_0000_0000_00FE, 1'b0, 1'b0, 2, 1};
        vecs[10] = '{3'b011, 64'h1008,              64'h0123_4567_89AB_CDEF, 64'h0,                  64'h0123_4567_89AB_CDEF, 1'b0, 1'b0, 2, 1};
        vecs[11] = '{3'b111, 64'h1001,              64'h0,                   64'h0,                  64'h0,                   1'b0, 1'b1, 1, 0};
        vecs[12] = '{3'b011, 64'hFFFF_FFFF_FFFF_FFFC, 64'hAABB_CCDD_0000_0000, 64'h0000_0000_1122_3344, 64'h1122_3344_AABB_CCDD, 1'b0, 1'b0, 3, 2};
        vecs[13] = '{3'b000, 64'h1000,              64'hFFFF_FFFF_FFFF_FF7F, 64'h0,                  64'h0000_0000_0000_007F, 1'b0, 1'b0, 2, 1};

        // Reset state.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.req_ready", 64'(o_req_ready), 64'd1);
        check("rst.mem_req", 64'(o_mem_req), 64'd0);
        check("rst.mem_addr", o_mem_addr, 64'd0);
        check("rst.resp_valid", 64'(o_resp_valid), 64'd0);
        check("rst.data", o_data, 64'd0);
        check("rst.flags", {62'd0, o_load_addr_ma, o_illegal_instr}, 64'd0);

        for (int i = 0; i < 14; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Illegal response held stable while the consumer stalls.
        i_func_3 = 3'b111; i_addr = 64'h2000; i_req_valid = 1'b1;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold%0d.valid", c), 64'(o_resp_valid), 64'd1);
            check($sformatf("hold%0d.ill", c), 64'(o_illegal_instr), 64'd1);
            check($sformatf("hold%0d.data", c), o_data, 64'd0);
            check($sformatf("hold%0d.mem_req", c), 64'(o_mem_req), 64'd0);
        end
        i_resp_ready = 1'b1;
        @(posedge clk); #1;
        i_resp_ready = 1'b0;
        @(negedge clk);

        // Crossing LD stalled in the second access, then aborted by reset.
        mem_base = 64'h1000; mem_lo = vecs[2].lo; mem_hi = vecs[2].hi;
        i_func_3 = 3'b011; i_addr = 64'h1006; i_req_valid = 1'b1;
        @(posedge clk); #1;
        i_req_valid = 1'b0;
        @(negedge clk);
        check("abort.acc0_addr", o_mem_addr, 64'h1000);
        check("abort.acc0_req", 64'(o_mem_req), 64'd1);
        @(negedge clk);
        mem_en = 1'b0;
        for (int c = 0; c < 2; c++) begin
            check($sformatf("stall%0d.req", c), 64'(o_mem_req), 64'd1);
            check($sformatf("stall%0d.addr", c), o_mem_addr, 64'h1008);
            check($sformatf("stall%0d.valid", c), 64'(o_resp_valid), 64'd0);
            @(negedge clk);
        end
        #1 rst = 1'b1;
        #1;
        check("abort.mem_req", 64'(o_mem_req), 64'd0);
        check("abort.resp_valid", 64'(o_resp_valid), 64'd0);
        check("abort.req_ready", 64'(o_req_ready), 64'd1);
        check("abort.mem_addr", o_mem_addr, 64'd0);
        #1 rst = 1'b0;
        mem_en = 1'b1;
        @(negedge clk);
        apply(vecs[2], "after_abort");

        // MISALIGN_EN=0 instance: misaligned LH flags without a memory access.
        m_func_3 = 3'b001; m_addr = 64'h1001; m_req_valid = 1'b1;
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        @(negedge clk);
        check("nm_ma.valid", 64'(m_resp_valid), 64'd1);
        check("nm_ma.ma", 64'(m_ma), 64'd1);
        check("nm_ma.ill", 64'(m_ill), 64'd0);
        check("nm_ma.data", m_data, 64'd0);
        check("nm_ma.accesses", 64'(m_acc_cnt), 64'd0);
        m_resp_ready = 1'b1;
        @(posedge clk); #1;
        m_resp_ready = 1'b0;
        @(negedge clk);

        // Illegal takes priority over misaligned.
        m_func_3 = 3'b111; m_addr = 64'h1001; m_req_valid = 1'b1;
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        @(negedge clk);
        check("nm_pri.ill", 64'(m_ill), 64'd1);
        check("nm_pri.ma", 64'(m_ma), 64'd0);
        m_resp_ready = 1'b1;
        @(posedge clk); #1;
        m_resp_ready = 1'b0;
        @(negedge clk);

        // Aligned LW still goes to memory.
        m_func_3 = 3'b010; m_addr = 64'h1004; m_req_valid = 1'b1;
        check("nm_lw.req_ready", 64'(m_req_ready), 64'd1);
        @(posedge clk); #1;
        m_req_valid = 1'b0;
        @(negedge clk);
        check("nm_lw.mem_addr", m_mem_addr, 64'h1000);
        @(negedge clk);
        check("nm_lw.valid", 64'(m_resp_valid), 64'd1);
        check("nm_lw.data", m_data, 64'hFFFF_FFFF_8765_4321);
        check("nm_lw.ma", 64'(m_ma), 64'd0);
        check("nm_lw.accesses", 64'(m_acc_cnt), 64'd1);
        m_resp_ready = 1'b1;
        @(posedge clk); #1;
        m_resp_ready = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
